// File: rtl/fwd_pipe_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding unit.
// Holds the operand-select encodings, the pipeline slot record and the
// default widths used by fwd_pipe_unit and fwd_src_sel.
package fwd_pipe_unit_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_RADDR_W = 5;
  // Slot records carry rd at this fixed width so a single typedef serves
  // every build. RADDR_W of the unit must not exceed it.
  localparam int MAX_RADDR_W = 8;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                   valid;
    logic [MAX_RADDR_W-1:0] rd;
    logic                   reg_write;
    logic                   mem_read;
  } slot_t;

  // True when slot s will write register addr. Loads are excluded unless
  // allow_load is set, because a load's MEM-stage result is its address.
  function automatic logic slot_hits(input slot_t s,
                                     input logic [MAX_RADDR_W-1:0] addr,
                                     input logic allow_load);
    return s.valid & s.reg_write & (allow_load | ~s.mem_read) &
           (s.rd != '0) & (s.rd == addr);
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source forwarding comparator and operand mux.
// Ports:
//   i_rs_addr / i_rs_used / i_rs_data : EX-slot source address, use flag, latched data
//   i_mem_slot / i_wb_slot            : destination records of MEM and WB slots
//   i_mem_result / i_wb_result        : MEM and WB result buses
//   o_operand / o_sel                 : selected operand and its source encoding
module fwd_src_sel
  import fwd_pipe_unit_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic [RADDR_W-1:0] i_rs_addr,
  input  logic               i_rs_used,
  input  logic [XLEN-1:0]    i_rs_data,
  input  slot_t              i_mem_slot,
  input  slot_t              i_wb_slot,
  input  logic [XLEN-1:0]    i_mem_result,
  input  logic [XLEN-1:0]    i_wb_result,
  output logic [XLEN-1:0]    o_operand,
  output logic [1:0]         o_sel
);

  logic [MAX_RADDR_W-1:0] w_addr;
  logic                   w_mem_hit;
  logic                   w_wb_hit;

  assign w_addr    = MAX_RADDR_W'(i_rs_addr);
  assign w_mem_hit = i_rs_used & slot_hits(i_mem_slot, w_addr, 1'b0);
  assign w_wb_hit  = i_rs_used & slot_hits(i_wb_slot, w_addr, 1'b1);

  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    o_operand = i_rs_data;
    o_sel     = FWD_REG;
    if (w_mem_hit) begin
      o_operand = i_mem_result;
      o_sel     = FWD_MEM;
    end else if (w_wb_hit) begin
      o_operand = i_wb_result;
      o_sel     = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_pipe_unit.sv
// EX-stage operand forwarding unit with load-use stall and bubble/flush.
// Tracks EX/MEM/WB destination slots beside the ID/EX register.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_id_*          : ID-stage decode info and register-file read data
//   i_mem_result    : EX/MEM ALU result
//   i_wb_result     : MEM/WB writeback data
//   i_flush         : kill the instruction entering EX
//   i_pipe_hold     : freeze all slots (flush ignored while held)
//   o_stall_id      : load-use hazard, hold PC and IF/ID
//   o_ex_operand    : forwarded EX operands, source 0 in the LSBs
//   o_fwd_sel       : per source 0=reg, 1=WB, 2=MEM
module fwd_pipe_unit
  import fwd_pipe_unit_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NUM_SRC = 2,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_id_valid,
  input  logic [NUM_SRC*RADDR_W-1:0] i_id_rs_addr,
  input  logic [NUM_SRC-1:0]         i_id_rs_used,
  input  logic [NUM_SRC*XLEN-1:0]    i_id_rs_data,
  input  logic [RADDR_W-1:0]         i_id_rd,
  input  logic                       i_id_reg_write,
  input  logic                       i_id_mem_read,
  input  logic [XLEN-1:0]            i_mem_result,
  input  logic [XLEN-1:0]            i_wb_result,
  input  logic                       i_flush,
  input  logic                       i_pipe_hold,
  output logic                       o_stall_id,
  output logic [NUM_SRC*XLEN-1:0]    o_ex_operand,
  output logic [NUM_SRC*2-1:0]       o_fwd_sel
);

  slot_t                      r_ex_slot;
  slot_t                      r_mem_slot;
  slot_t                      r_wb_slot;
  logic [NUM_SRC*RADDR_W-1:0] r_ex_rs_addr;
  logic [NUM_SRC-1:0]         r_ex_rs_used;
  logic [NUM_SRC*XLEN-1:0]    r_ex_rs_data;

  logic                       w_hazard;
  logic                       w_ex_load;
  logic [NUM_SRC*XLEN-1:0]    w_id_data;
  slot_t                      w_ex_next;

  // Any used ID source matching the EX destination.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_id_rs_used[i] &&
          (MAX_RADDR_W'(i_id_rs_addr[i*RADDR_W +: RADDR_W]) == r_ex_slot.rd))
        w_hazard = 1'b1;
    end
  end

  assign o_stall_id = i_id_valid & ~i_flush & r_ex_slot.valid &
                      r_ex_slot.mem_read & (r_ex_slot.rd != '0) & w_hazard;
  assign w_ex_load  = i_id_valid & ~o_stall_id & ~i_flush;

  // The register file writes the WB value on the same edge that loads EX,
  // so ID's read data is stale for that register; capture wb_result instead.
  always_comb begin
    w_id_data = i_id_rs_data;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (slot_hits(r_wb_slot, MAX_RADDR_W'(i_id_rs_addr[i*RADDR_W +: RADDR_W]), 1'b1))
        w_id_data[i*XLEN +: XLEN] = i_wb_result;
    end
  end

  always_comb begin
    w_ex_next = '0;
    if (w_ex_load) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rd        = MAX_RADDR_W'(i_id_rd);
      w_ex_next.reg_write = i_id_reg_write;
      w_ex_next.mem_read  = i_id_mem_read;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_slot    <= '0;
      r_mem_slot   <= '0;
      r_wb_slot    <= '0;
      r_ex_rs_addr <= '0;
      r_ex_rs_used <= '0;
      r_ex_rs_data <= '0;
    end else if (!i_pipe_hold) begin
      r_wb_slot    <= r_mem_slot;
      r_mem_slot   <= r_ex_slot;
      r_ex_slot    <= w_ex_next;
      r_ex_rs_addr <= w_ex_load ? i_id_rs_addr : '0;
      r_ex_rs_used <= w_ex_load ? i_id_rs_used : '0;
      r_ex_rs_data <= w_ex_load ? w_id_data    : '0;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_sel #(
      .XLEN    (XLEN),
      .RADDR_W (RADDR_W)
    ) u_sel (
      .i_rs_addr    (r_ex_rs_addr[g*RADDR_W +: RADDR_W]),
      .i_rs_used    (r_ex_rs_used[g]),
      .i_rs_data    (r_ex_rs_data[g*XLEN +: XLEN]),
      .i_mem_slot   (r_mem_slot),
      .i_wb_slot    (r_wb_slot),
      .i_mem_result (i_mem_result),
      .i_wb_result  (i_wb_result),
      .o_operand    (o_ex_operand[g*XLEN +: XLEN]),
      .o_sel        (o_fwd_sel[g*2 +: 2])
    );
  end

endmodule

// File: tb/tb_fwd_pipe_unit.sv
module tb_fwd_pipe_unit;
  import fwd_pipe_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int NS   = 3;
  localparam int RW   = 5;

  logic               clk;
  logic               rst_n;
  logic               id_valid;
  logic [NS*RW-1:0]   id_rs_addr;
  logic [NS-1:0]      id_rs_used;
  logic [NS*XLEN-1:0] id_rs_data;
  logic [RW-1:0]      id_rd;
  logic               id_reg_write;
  logic               id_mem_read;
  logic [XLEN-1:0]    mem_result;
  logic [XLEN-1:0]    wb_result;
  logic               flush;
  logic               pipe_hold;
  logic               stall_id;
  logic [NS*XLEN-1:0] ex_operand;
  logic [NS*2-1:0]    fwd_sel;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string           tag;
    int              lane;
    logic [1:0]      sel;
    logic [XLEN-1:0] op;
  } exp_t;

  exp_t exp_q[$];

  fwd_pipe_unit #(.XLEN(XLEN), .NUM_SRC(NS), .RADDR_W(RW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_id_valid     (id_valid),
    .i_id_rs_addr   (id_rs_addr),
    .i_id_rs_used   (id_rs_used),
    .i_id_rs_data   (id_rs_data),
    .i_id_rd        (id_rd),
    .i_id_reg_write (id_reg_write),
    .i_id_mem_read  (id_mem_read),
    .i_mem_result   (mem_result),
    .i_wb_result    (wb_result),
    .i_flush        (flush),
    .i_pipe_hold    (pipe_hold),
    .o_stall_id     (stall_id),
    .o_ex_operand   (ex_operand),
    .o_fwd_sel      (fwd_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(input string tag, input int lane,
                              input logic [1:0] sel, input logic [XLEN-1:0] op);
    exp_t e;
    e.tag = tag; e.lane = lane; e.sel = sel; e.op = op;
    return e;
  endfunction

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid     = 1'b0;
    id_rs_addr   = '0;
    id_rs_used   = '0;
    id_rs_data   = '0;
    id_rd        = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
  endtask

  // Two-source instruction on lanes 0 and 1; lane 2 unused.
  task automatic drive_instr(input logic [RW-1:0] rd, input logic wr, input logic ld,
                             input logic [RW-1:0] rs0, input logic [RW-1:0] rs1,
                             input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
    id_valid     = 1'b1;
    id_rd        = rd;
    id_reg_write = wr;
    id_mem_read  = ld;
    id_rs_addr   = {5'd0, rs1, rs0};
    id_rs_used   = 3'b011;
    id_rs_data   = {32'h0, d1, d0};
  endtask

  task automatic drain();
    drive_idle();
    flush     = 1'b0;
    pipe_hold = 1'b0;
    repeat (3) to_pos();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    flush      = 1'b0;
    pipe_hold  = 1'b0;
    mem_result = 32'hFFFF_0001;
    wb_result  = 32'hFFFF_0002;
    drive_instr(5'd3, 1'b1, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22);
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL reset_stall got %0b expected 0", stall_id); else n_pass++;
    n_total++; if (ex_operand !== '0) $display("FAIL reset_operand got %h expected 0", ex_operand); else n_pass++;
    n_total++; if (fwd_sel !== '0) $display("FAIL reset_sel got %h expected 0", fwd_sel); else n_pass++;
    to_pos();
    n_total++; if (dut.r_ex_slot.valid !== 1'b0) $display("FAIL reset_ex_hold got %0b expected 0", dut.r_ex_slot.valid); else n_pass++;
    drive_idle();
    to_neg();
    rst_n = 1'b1;
    to_pos();
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive_instr(5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
    to_pos();
    drive_instr(5'd7, 1'b1, 1'b0, 5'd5, 5'd3, 32'hDEAD, 32'h33);
    exp_q.push_back(mk("b2b_rs1", 0, FWD_MEM, 32'h10));
    exp_q.push_back(mk("b2b_rs2", 1, FWD_REG, 32'h33));
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL b2b_stall got %0b expected 0", stall_id); else n_pass++;
    to_pos();
    drive_idle();
    mem_result = 32'h10;
    wb_result  = 32'h999;
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL b2b_ex_stall got %0b expected 0", stall_id); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++; if (fwd_sel[e.lane*2 +: 2] !== e.sel) $display("FAIL %s_sel got %0d expected %0d", e.tag, fwd_sel[e.lane*2 +: 2], e.sel); else n_pass++;
      n_total++; if (ex_operand[e.lane*XLEN +: XLEN] !== e.op) $display("FAIL %s_op got %h expected %h", e.tag, ex_operand[e.lane*XLEN +: XLEN], e.op); else n_pass++;
    end
    drain();
  endtask

  task automatic test_distance();
    exp_t e;
    // distance 2: producer in WB when the consumer is in EX
    drive_instr(5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
    to_pos();
    drive_idle();
    to_pos();
    drive_instr(5'd8, 1'b1, 1'b0, 5'd5, 5'd4, 32'hBAD, 32'h44);
    exp_q.push_back(mk("dist2_rs1", 0, FWD_WB, 32'h20));
    exp_q.push_back(mk("dist2_rs2", 1, FWD_REG, 32'h44));
    to_pos();
    drive_idle();
    wb_result  = 32'h20;
    mem_result = 32'h777;
    to_neg();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++; if (fwd_sel[e.lane*2 +: 2] !== e.sel) $display("FAIL %s_sel got %0d expected %0d", e.tag, fwd_sel[e.lane*2 +: 2], e.sel); else n_pass++;
      n_total++; if (ex_operand[e.lane*XLEN +: XLEN] !== e.op) $display("FAIL %s_op got %h expected %h", e.tag, ex_operand[e.lane*XLEN +: XLEN], e.op); else n_pass++;
    end
    drain();
    // distance 3: value captured by write-through while loading EX
    drive_instr(5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
    to_pos();
    drive_idle();
    to_pos();
    to_pos();
    drive_instr(5'd8, 1'b1, 1'b0, 5'd5, 5'd4, 32'hBAD, 32'h44);
    wb_result = 32'h20;
    exp_q.push_back(mk("dist3_rs1", 0, FWD_REG, 32'h20));
    exp_q.push_back(mk("dist3_rs2", 1, FWD_REG, 32'h44));
    to_pos();
    drive_idle();
    wb_result  = 32'h555;
    mem_result = 32'h666;
    to_neg();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++; if (fwd_sel[e.lane*2 +: 2] !== e.sel) $display("FAIL %s_sel got %0d expected %0d", e.tag, fwd_sel[e.lane*2 +: 2], e.sel); else n_pass++;
      n_total++; if (ex_operand[e.lane*XLEN +: XLEN] !== e.op) $display("FAIL %s_op got %h expected %h", e.tag, ex_operand[e.lane*XLEN +: XLEN], e.op); else n_pass++;
    end
    drain();
  endtask

  task automatic test_load_use();
    exp_t e;
    drive_instr(5'd6, 1'b1, 1'b1, 5'd1, 5'd2, 32'h100, 32'h0);
    to_pos();
    drive_instr(5'd9, 1'b1, 1'b0, 5'd8, 5'd6, 32'h88, 32'hBAD);
    exp_q.push_back(mk("lu_rs2", 1, FWD_WB, 32'hCAFE));
    exp_q.push_back(mk("lu_rs1", 0, FWD_REG, 32'h88));
    to_neg();
    n_total++; if (stall_id !== 1'b1) $display("FAIL lu_stall got %0b expected 1", stall_id); else n_pass++;
    to_pos();
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL lu_stall_once got %0b expected 0", stall_id); else n_pass++;
    n_total++; if (dut.r_ex_slot.valid !== 1'b0) $display("FAIL lu_bubble got %0b expected 0", dut.r_ex_slot.valid); else n_pass++;
    to_pos();
    drive_idle();
    wb_result  = 32'hCAFE;
    mem_result = 32'h1000;
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL lu_ex_stall got %0b expected 0", stall_id); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++; if (fwd_sel[e.lane*2 +: 2] !== e.sel) $display("FAIL %s_sel got %0d expected %0d", e.tag, fwd_sel[e.lane*2 +: 2], e.sel); else n_pass++;
      n_total++; if (ex_operand[e.lane*XLEN +: XLEN] !== e.op) $display("FAIL %s_op got %h expected %h", e.tag, ex_operand[e.lane*XLEN +: XLEN], e.op); else n_pass++;
    end
    drain();
  endtask

  task automatic test_x0();
    exp_t e;
    drive_instr(5'd0, 1'b1, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
    to_pos();
    drive_instr(5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    exp_q.push_back(mk("x0_rs1", 0, FWD_REG, 32'h0));
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL x0_stall got %0b expected 0", stall_id); else n_pass++;
    to_pos();
    drive_idle();
    mem_result = 32'h1234;
    wb_result  = 32'h5678;
    to_neg();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++; if (fwd_sel[e.lane*2 +: 2] !== e.sel) $display("FAIL %s_sel got %0d expected %0d", e.tag, fwd_sel[e.lane*2 +: 2], e.sel); else n_pass++;
      n_total++; if (ex_operand[e.lane*XLEN +: XLEN] !== e.op) $display("FAIL %s_op got %h expected %h", e.tag, ex_operand[e.lane*XLEN +: XLEN], e.op); else n_pass++;
    end
    drain();
    drive_instr(5'd0, 1'b1, 1'b1, 5'd1, 5'd2, 32'h1, 32'h2);
    to_pos();
    drive_instr(5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL x0_load_stall got %0b expected 0", stall_id); else n_pass++;
    drain();
  endtask

  task automatic test_flush_hold();
    exp_t e;
    drive_instr(5'd6, 1'b1, 1'b1, 5'd1, 5'd2, 32'h1, 32'h2);
    to_pos();
    drive_instr(5'd9, 1'b1, 1'b0, 5'd6, 5'd3, 32'hBAD, 32'h3);
    flush = 1'b1;
    to_neg();
    n_total++; if (stall_id !== 1'b0) $display("FAIL flush_stall got %0b expected 0", stall_id); else n_pass++;
    to_pos();
    flush = 1'b0;
    drive_idle();
    to_neg();
    n_total++; if (dut.r_ex_slot.valid !== 1'b0) $display("FAIL flush_bubble got %0b expected 0", dut.r_ex_slot.valid); else n_pass++;
    n_total++; if (fwd_sel !== '0) $display("FAIL flush_sel got %h expected 0", fwd_sel); else n_pass++;
    drain();
    // Forwarding state frozen by pipe_hold while flush and a new ID are offered
    drive_instr(5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
    to_pos();
    drive_instr(5'd7, 1'b1, 1'b0, 5'd5, 5'd3, 32'hDEAD, 32'h33);
    to_pos();
    mem_result = 32'h10;
    wb_result  = 32'h999;
    pipe_hold  = 1'b1;
    flush      = 1'b1;
    drive_instr(5'd12, 1'b1, 1'b1, 5'd7, 5'd7, 32'h5, 32'h6);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk($sformatf("hold%0d_rs1", k), 0, FWD_MEM, 32'h10));
      exp_q.push_back(mk($sformatf("hold%0d_rs2", k), 1, FWD_REG, 32'h33));
      to_neg();
      n_total++; if (stall_id !== 1'b0) $display("FAIL hold%0d_stall got %0b expected 0", k, stall_id); else n_pass++;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++; if (fwd_sel[e.lane*2 +: 2] !== e.sel) $display("FAIL %s_sel got %0d expected %0d", e.tag, fwd_sel[e.lane*2 +: 2], e.sel); else n_pass++;
        n_total++; if (ex_operand[e.lane*XLEN +: XLEN] !== e.op) $display("FAIL %s_op got %h expected %h", e.tag, ex_operand[e.lane*XLEN +: XLEN], e.op); else n_pass++;
      end
      to_pos();
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    drive_instr(5'd6, 1'b1, 1'b1, 5'd1, 5'd2, 32'hAAAA, 32'hBBBB);
    to_pos();
    id_valid     = 1'b1;
    id_rd        = 5'd13;
    id_reg_write = 1'b1;
    id_mem_read  = 1'b0;
    id_rs_addr   = {5'd6, 5'd4, 5'd3};
    id_rs_used   = 3'b100;
    id_rs_data   = {32'h66, 32'h44, 32'h33};
    to_neg();
    n_total++; if (stall_id !== 1'b1) $display("FAIL rms_stall_pre got %0b expected 1", stall_id); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (stall_id !== 1'b0) $display("FAIL rms_stall got %0b expected 0", stall_id); else n_pass++;
    n_total++; if (ex_operand !== '0) $display("FAIL rms_operand got %h expected 0", ex_operand); else n_pass++;
    n_total++; if (fwd_sel !== '0) $display("FAIL rms_sel got %h expected 0", fwd_sel); else n_pass++;
    to_pos();
    drive_idle();
    to_neg();
    rst_n = 1'b1;
    to_pos();
    drive_instr(5'd14, 1'b1, 1'b0, 5'd6, 5'd1, 32'h42, 32'h1);
    mem_result = 32'hAB;
    wb_result  = 32'hCD;
    exp_q.push_back(mk("rms_first", 0, FWD_REG, 32'h42));
    to_pos();
    drive_idle();
    to_neg();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++; if (fwd_sel[e.lane*2 +: 2] !== e.sel) $display("FAIL %s_sel got %0d expected %0d", e.tag, fwd_sel[e.lane*2 +: 2], e.sel); else n_pass++;
      n_total++; if (ex_operand[e.lane*XLEN +: XLEN] !== e.op) $display("FAIL %s_op got %h expected %h", e.tag, ex_operand[e.lane*XLEN +: XLEN], e.op); else n_pass++;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_x0();
    test_flush_hold();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
